// File: rtl/data_memory_banked.sv
// rtl/data_memory_banked.sv - banked data/stack memory with req/ready handshake and wait states
// Optional alignment faulting is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_memory_banked #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 256,
    parameter int                    STACK_DEPTH = 64,
    parameter logic [ADDR_WIDTH-1:0] STACK_TOP   = 'h7FFF_FFFC,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  fault
);
    localparam int DIDX_W = $clog2(DEPTH);
    localparam int SIDX_W = $clog2(STACK_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] DATA_LIMIT = ADDR_WIDTH'(4 * DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STACK_LO   = STACK_TOP - ADDR_WIDTH'(4 * (STACK_DEPTH - 1));
    localparam logic [ADDR_WIDTH-1:0] STACK_HI   = STACK_TOP + ADDR_WIDTH'(3);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state;
    logic [3:0]              count;
    logic                    cap_we;
    logic [1:0]              cap_size;
    logic                    cap_uns;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [31:0]             cap_wdata;

    logic [31:0] data_mem  [DEPTH];
    logic [31:0] stack_mem [STACK_DEPTH];

    logic                  idle;
    logic                  cur_we;
    logic [1:0]            cur_size;
    logic                  cur_uns;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic                  enter_resp;
    logic                  in_data;
    logic                  in_stack;
    logic                  misaligned;
    logic                  bad;
    logic [ADDR_WIDTH-1:0] stack_off;
    logic [DIDX_W-1:0]     didx;
    logic [SIDX_W-1:0]     sidx;
    logic [31:0]           word;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [31:0]           load_value;
    logic [3:0]            wmask;
    logic [31:0]           wlanes;
    logic                  unused_bits;

    // With zero wait states the access completes on the accepting edge,
    // so the live inputs are used instead of the not-yet-captured copies.
    always_comb begin
        idle      = (state == IDLE);
        cur_we    = idle ? we          : cap_we;
        cur_size  = idle ? size        : cap_size;
        cur_uns   = idle ? unsigned_ld : cap_uns;
        cur_addr  = idle ? address     : cap_addr;
        cur_wdata = idle ? write_data  : cap_wdata;
        enter_resp = (idle && req && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (count == 4'd1));
    end

    always_comb begin
        in_data   = (cur_addr < DATA_LIMIT);
        in_stack  = (cur_addr >= STACK_LO) && (cur_addr <= STACK_HI);
        stack_off = STACK_TOP - {cur_addr[ADDR_WIDTH-1:2], 2'b00};
        didx      = cur_addr[DIDX_W+1:2];
        sidx      = stack_off[SIDX_W+1:2];
`ifdef DMEM_ALIGN_CHECK_EN
        misaligned = ((cur_size == 2'b01) && cur_addr[0]) ||
                     (cur_size[1] && (cur_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        bad = !(in_data || in_stack) || misaligned;
        unused_bits = ^{stack_off[ADDR_WIDTH-1:SIDX_W+2], stack_off[1:0],
                        cur_addr[ADDR_WIDTH-1:DIDX_W+2]};
    end

    always_comb begin
        word      = in_data ? data_mem[didx] : stack_mem[sidx];
        lane_byte = word[8*cur_addr[1:0] +: 8];
        lane_half = word[16*cur_addr[1] +: 16];
        case (cur_size)
            2'b00:   load_value = cur_uns ? {24'd0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
            2'b01:   load_value = cur_uns ? {16'd0, lane_half} : {{16{lane_half[15]}}, lane_half};
            default: load_value = word;
        endcase
    end

    // Store data is replicated across lanes so only the byte mask depends on the address.
    always_comb begin
        case (cur_size)
            2'b00: begin
                wmask  = 4'b0001 << cur_addr[1:0];
                wlanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                wmask  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{cur_wdata[15:0]}};
            end
            default: begin
                wmask  = 4'b1111;
                wlanes = cur_wdata;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_n && enter_resp && cur_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    if (in_data)
                        data_mem[didx][8*i +: 8] <= wlanes[8*i +: 8];
                    else
                        stack_mem[sidx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= 4'd0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            read_data <= 32'd0;
            cap_we    <= 1'b0;
            cap_size  <= 2'b00;
            cap_uns   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
        end else begin
            ready <= 1'b0;
            fault <= 1'b0;
            if (enter_resp) begin
                ready     <= 1'b1;
                fault     <= bad;
                read_data <= (bad || cur_we) ? 32'd0 : load_value;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_size  <= size;
                        cap_uns   <= unsigned_ld;
                        cap_addr  <= address;
                        cap_wdata <= write_data;
                        busy      <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            count <= 4'(WAIT_STATES);
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1)
                        state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_banked.sv
// tb/tb_data_memory_banked.sv - randomized bench for data_memory_banked against a byte-level model
module tb_data_memory_banked;
    localparam int          AW    = 32;
    localparam int          DEPTH = 256;
    localparam int          SDEP  = 64;
    localparam logic [31:0] STOP  = 32'h7FFF_FFFC;
    localparam int          WS    = 1;
    localparam logic [31:0] SLO   = STOP - 32'(4 * (SDEP - 1));

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          unsigned_ld;
    logic [AW-1:0] address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic          busy;
    logic          fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [logic [31:0]];

    data_memory_banked #(
        .ADDR_WIDTH(AW), .DEPTH(DEPTH), .STACK_DEPTH(SDEP),
        .STACK_TOP(STOP), .WAIT_STATES(WS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready), .busy(busy), .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] a);
        bit ok;
        ok = (a < 32'(4 * DEPTH)) || (a >= SLO && a <= STOP + 32'd3);
`ifdef DMEM_ALIGN_CHECK_EN
        if (sz == 2'b01 && a[0]) ok = 0;
        if (sz[1] && a[1:0] != 2'b00) ok = 0;
`endif
        return !ok;
    endfunction

    task automatic model_op(input bit w, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] erd, output bit eflt);
        int nb;
        logic [31:0] ea;
        logic [31:0] v;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        ea = a & ~(32'(nb) - 32'd1);
        eflt = model_fault(sz, a);
        erd = 32'd0;
        if (!eflt) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mem[ea + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mem[ea + 32'(i)];
                if (nb == 1 && !uns && v[7])  v[31:8]  = 24'hFFFFFF;
                if (nb == 2 && !uns && v[15]) v[31:16] = 16'hFFFF;
                erd = v;
            end
        end
    endtask

    task automatic run_op(input string tag, input bit w, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] erd;
        bit eflt;
        int n;
        bit got;
        logic flt;
        n = 0;
        while (busy && n < 20) begin @(negedge clock); n++; end
        @(negedge clock);
        req = 1'b1; we = w; size = sz; unsigned_ld = uns; address = a; write_data = wd;
        @(posedge clock);
        #1 req = 1'b0;
        model_op(w, sz, uns, a, wd, erd, eflt);
        n = 0; got = 0; rd = 32'd0; flt = 1'b0;
        while (!got && n < 40) begin
            @(negedge clock);
            n++;
            if (ready) begin got = 1; rd = read_data; flt = fault; end
        end
        check({tag, "_latency"}, 32'(n), 32'(WS + 1));
        check({tag, "_fault"}, {31'd0, flt}, {31'd0, eflt});
        check({tag, "_rdata"}, rd, erd);
        @(negedge clock);
        check({tag, "_pulse"}, {31'd0, ready}, 32'd0);
    endtask

    logic [31:0] rd;
    logic [31:0] pool [16];
    int pulses;

    initial begin
        reset_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
        address = '0; write_data = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        reset_n = 1'b1;

        run_op("init0", 1, 2'b10, 0, 32'h0, 32'h1111_2222, rd);
        run_op("st10", 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, rd);
        run_op("ld10", 0, 2'b10, 0, 32'h10, 32'h0, rd);
        check("ld10_const", rd, 32'hDEAD_BEEF);

        run_op("st20", 1, 2'b10, 0, 32'h20, 32'h80FF_7F01, rd);
        run_op("lb22s", 0, 2'b00, 0, 32'h22, 32'h0, rd);
        check("lb22s_const", rd, 32'hFFFF_FFFF);
        run_op("lb22u", 0, 2'b00, 1, 32'h22, 32'h0, rd);
        check("lb22u_const", rd, 32'h0000_00FF);
        run_op("lh22s", 0, 2'b01, 0, 32'h22, 32'h0, rd);
        check("lh22s_const", rd, 32'hFFFF_80FF);

        run_op("st_top", 1, 2'b10, 0, STOP, 32'h1234_5678, rd);
        run_op("st_top4", 1, 2'b10, 0, STOP - 32'd4, 32'hCAFE_F00D, rd);
        run_op("ld_top", 0, 2'b10, 0, STOP, 32'h0, rd);
        check("ld_top_const", rd, 32'h1234_5678);
        run_op("ld_top4", 0, 2'b10, 0, STOP - 32'd4, 32'h0, rd);
        check("ld_top4_const", rd, 32'hCAFE_F00D);
        run_op("ld0", 0, 2'b10, 0, 32'h0, 32'h0, rd);
        check("ld0_const", rd, 32'h1111_2222);

        run_op("oor_st", 1, 2'b10, 0, 32'(4 * DEPTH), 32'hBAD0_BAD0, rd);
        run_op("oor_ld", 0, 2'b10, 0, 32'(4 * DEPTH), 32'h0, rd);
        run_op("oor_after", 0, 2'b10, 0, 32'h0, 32'h0, rd);
        check("oor_after_const", rd, 32'h1111_2222);

        run_op("align_st", 1, 2'b10, 0, 32'h13, 32'hA5A5_A5A5, rd);
        run_op("align_ld", 0, 2'b10, 0, 32'h10, 32'h0, rd);
`ifdef DMEM_ALIGN_CHECK_EN
        check("align_const", rd, 32'hDEAD_BEEF);
`else
        check("align_const", rd, 32'hA5A5_A5A5);
`endif

        // req held for five rising edges: accepts happen every WS+2 edges
        @(negedge clock);
        req = 1'b1; we = 1'b0; size = 2'b10; address = 32'h0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (ready) pulses++;
        end
        req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (ready) pulses++;
        end
        check("hold_accepts", 32'(pulses), 32'((5 + WS + 1) / (WS + 2)));

        // reset during WAIT of a store aborts it
        @(negedge clock);
        req = 1'b1; we = 1'b1; size = 2'b10; address = 32'h0; write_data = 32'h7777_7777;
        @(posedge clock);
        #1 req = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1 check("abort_busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (ready) pulses++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (ready) pulses++;
        end
        check("abort_no_ready", 32'(pulses), 32'd0);
        run_op("abort_ld", 0, 2'b10, 0, 32'h0, 32'h0, rd);
        check("abort_const", rd, 32'h1111_2222);

        for (int i = 0; i < 8; i++) pool[i] = 32'(4 * i);
        for (int i = 0; i < 4; i++) pool[8 + i] = STOP - 32'(4 * i);
        pool[12] = 32'(4 * DEPTH); pool[13] = SLO - 32'd4;
        pool[14] = 32'h8000_0000; pool[15] = 32'hFFFF_FFFC;
        for (int i = 0; i < 12; i++) run_op("rinit", 1, 2'b10, 0, pool[i], $urandom, rd);
        for (int i = 0; i < 150; i++) begin
            run_op("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)] + 32'($urandom_range(0, 3)),
                   $urandom, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
